pll_lock_sequencer: RTL and testbench
=====================================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4: number of cycles pll_resetb is held low per PLL reset attempt (min 1).
REQ-002 SHALL have parameter LOCK_STABLE, default 8: number of consecutive synchronized lock cycles required before release (min 1).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 64: maximum number of cycles spent in WAIT_LOCK per attempt (must exceed LOCK_STABLE).
REQ-004 SHALL have parameter MAX_RETRIES, default 2: number of re-attempts allowed after the first timeout before entering FAULT.
REQ-005 SHALL have port clock_in, input, 1: single clock, the PLL reference clock domain.
REQ-006 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port locked, input, 1: PLL LOCK, asynchronous to clock_in.
REQ-008 SHALL have port restart, input, 1: synchronous single-cycle request to re-sequence the PLL.
REQ-009 SHALL have port pll_resetb, output, 1: drives the PLL RESETB pin; low holds the PLL in reset.
REQ-010 SHALL have port sys_rst_n, output, 1: active-low reset for downstream logic on the PLL output clock.
REQ-011 SHALL have port ready, output, 1: high while in RUN.
REQ-012 SHALL have port fault, output, 1: high while in FAULT.
REQ-013 SHALL have port state, output, 3: current state encoding; PLL_RST=0, WAIT_LOCK=1, RUN=2, FAULT=3.

Function
REQ-014 SHALL pass locked through a two-flop synchronizer to produce lock_s; all decisions SHALL use lock_s only.
REQ-015 SHALL drive all outputs from registers, with no combinational path from any input to any output.
REQ-016 PLL_RST: pll_resetb=0, sys_rst_n=0; after exactly RST_CYCLES cycles SHALL go to WAIT_LOCK, with stable and timeout counters cleared.
REQ-017 WAIT_LOCK: pll_resetb=1, sys_rst_n=0; the stable counter SHALL increment when lock_s=1 and clear to 0 when lock_s=0.
REQ-018 WAIT_LOCK: once lock_s has been 1 for LOCK_STABLE consecutive cycles, the next edge SHALL enter RUN; sys_rst_n=1 and ready=1 in the first RUN cycle.
REQ-019 WAIT_LOCK timeout: if LOCK_TIMEOUT cycles elapse without reaching REQ-018, the block SHALL go to PLL_RST and increment retry_cnt when retry_cnt<MAX_RETRIES, otherwise go to FAULT.
REQ-020 If the stable threshold and the timeout occur on the same cycle, the stable threshold SHALL win and the block SHALL enter RUN.
REQ-021 Entering RUN SHALL clear retry_cnt.
REQ-022 RUN: when lock_s=0 for one cycle, the block SHALL go to PLL_RST on the next edge, with sys_rst_n=0 and ready=0 from that edge; retry_cnt stays unchanged.
REQ-023 FAULT: pll_resetb=0, sys_rst_n=0, fault=1; the block SHALL remain in FAULT until restart.
REQ-024 restart=1 in any state SHALL force PLL_RST on the next edge and clear retry_cnt; restart SHALL take priority over every other transition.
REQ-025 Counters SHALL saturate and never wrap; counter widths SHALL be sized from $clog2 of their parameter.

Reset
REQ-026 On reset_n=0, asynchronously: state=PLL_RST, pll_resetb=0, sys_rst_n=0, ready=0, fault=0, synchronizer flops=0, all counters=0.
REQ-027 Reset release SHALL begin a full RST_CYCLES PLL reset, including when reset is asserted mid-RUN or mid-WAIT_LOCK.

Configuration
REQ-028 With macro PLL_LOCK_SEQUENCER_STATUS_EN defined, the block SHALL add an 8-bit output lock_loss_cnt, which counts RUN->PLL_RST transitions caused by loss of lock.
REQ-029 lock_loss_cnt SHALL saturate at 255, reset to 0 on reset_n, and not be cleared by restart.
REQ-030 Without PLL_LOCK_SEQUENCER_STATUS_EN, the lock_loss_cnt port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification (defaults RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, MAX_RETRIES=2)
REQ-031 Release reset, locked rises at cycle 10 and stays high -> pll_resetb high from cycle 4; sys_rst_n and ready high at cycle 20 (2 sync + 8 stable).
REQ-032 locked held low -> three WAIT_LOCK timeouts of 64 cycles, each preceded by a 4-cycle pll_resetb pulse; then fault=1, state=3, and the block stays in FAULT.
REQ-033 In RUN, drop locked for 1 cycle -> sys_rst_n low 3 edges later, pll_resetb low for 4 cycles, relock; lock_loss_cnt=1 when the macro is defined.
REQ-034 In WAIT_LOCK, locked toggles every 5 cycles -> the stable counter never reaches 8; timeout and retry occur; RUN is never entered.
REQ-035 In FAULT, pulse restart with locked high -> PLL_RST, then RUN 4+8+sync cycles later, retry_cnt=0; restart asserted mid-RUN forces PLL_RST.
REQ-036 Assert reset_n low mid-RUN asynchronously -> all outputs reach reset values within the same cycle without waiting for a clock edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives the PLL RESETB pin, qualifies the lock indication
// and releases the downstream reset once lock has been stable long enough.
// Timed-out lock attempts are retried, and the block parks in FAULT once the
// retries are used up.
// Optional feature macro: PLL_LOCK_SEQUENCER_STATUS_EN adds lock_loss_cnt, a
// saturating count of RUN exits caused by loss of lock.
module pll_lock_sequencer #(
    parameter int RST_CYCLES   = 4,
    parameter int LOCK_STABLE  = 8,
    parameter int LOCK_TIMEOUT = 64,
    parameter int MAX_RETRIES  = 2
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       restart,
    output logic       pll_resetb,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state
`ifdef PLL_LOCK_SEQUENCER_STATUS_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        RUN       = 3'd2,
        FAULT     = 3'd3
    } state_t;

    // Counter widths hold the full parameter value so they can saturate there.
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int YW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
    localparam logic [RW-1:0] RST_SAT     = RW'(RST_CYCLES);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);
    localparam logic [SW-1:0] STABLE_SAT  = SW'(LOCK_STABLE);
    localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_SAT     = TW'(LOCK_TIMEOUT);
    localparam logic [YW-1:0] RETRY_MAX   = YW'(MAX_RETRIES);

    logic [1:0]    sync_q;
    logic          lock_s;
    state_t        state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [SW-1:0] stable_cnt_q, stable_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [YW-1:0] retry_cnt_q, retry_cnt_d;
    logic          pll_resetb_q, pll_resetb_d;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;

    assign lock_s = sync_q[1];

    // Two-flop synchronizer bringing the asynchronous PLL lock into clock_in.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], locked};
    end

    // Next state, counter updates and the output values for the next state.
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        stable_cnt_d = stable_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        retry_cnt_d  = retry_cnt_q;
        if (restart) begin
            state_d     = PLL_RST;
            retry_cnt_d = '0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (rst_cnt_q == RST_LAST) state_d = WAIT_LOCK;
                    else if (rst_cnt_q != RST_SAT) rst_cnt_d = rst_cnt_q + 1'b1;
                end
                WAIT_LOCK: begin
                    if (!lock_s)                        stable_cnt_d = '0;
                    else if (stable_cnt_q != STABLE_SAT) stable_cnt_d = stable_cnt_q + 1'b1;
                    if (tmo_cnt_q != TMO_SAT) tmo_cnt_d = tmo_cnt_q + 1'b1;
                    // Reaching the stable threshold beats a simultaneous timeout.
                    if (lock_s && stable_cnt_q == STABLE_LAST) begin
                        state_d     = RUN;
                        retry_cnt_d = '0;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        if (retry_cnt_q < RETRY_MAX) begin
                            state_d     = PLL_RST;
                            retry_cnt_d = retry_cnt_q + 1'b1;
                        end else begin
                            state_d = FAULT;
                        end
                    end
                end
                RUN: begin
                    if (!lock_s) state_d = PLL_RST;
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = PLL_RST;
                end
            endcase
        end
        // Every entry into a state (including a restart re-entry) starts its timers fresh.
        if (restart || (state_d != state_q)) begin
            rst_cnt_d    = '0;
            stable_cnt_d = '0;
            tmo_cnt_d    = '0;
        end
        pll_resetb_d = (state_d == WAIT_LOCK) || (state_d == RUN);
        sys_rst_n_d  = (state_d == RUN);
        ready_d      = (state_d == RUN);
        fault_d      = (state_d == FAULT);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= PLL_RST;
            rst_cnt_q    <= '0;
            stable_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            retry_cnt_q  <= '0;
            pll_resetb_q <= 1'b0;
            sys_rst_n_q  <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            pll_resetb_q <= pll_resetb_d;
            sys_rst_n_q  <= sys_rst_n_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_resetb = pll_resetb_q;
    assign sys_rst_n  = sys_rst_n_q;
    assign ready      = ready_q;
    assign fault      = fault_q;
    assign state      = state_q;

`ifdef PLL_LOCK_SEQUENCER_STATUS_EN
    logic [7:0] loss_cnt_q;

    // Count RUN exits caused by lock loss; a restart exit is not a lock loss.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            loss_cnt_q <= 8'd0;
        end else if (!restart && (state_q == RUN) && !lock_s && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer with default parameters: a per-cycle table of
// input drives and expected outputs over a long scripted timeline, plus
// hand-written async-reset and reset-release sequences.
module tb_pll_lock_sequencer;

  localparam int RSTC = 4;
  localparam int STAB = 8;
  localparam int TMO  = 64;
  localparam int MAXR = 2;
  localparam int PER  = RSTC + TMO;
  localparam int LAST = 710;

  // Packed outputs: {0, pll_resetb, sys_rst_n, ready, fault, state[2:0]}
  localparam logic [7:0] O_RST   = 8'b0_0000_000;
  localparam logic [7:0] O_WAIT  = 8'b0_1000_001;
  localparam logic [7:0] O_RUN   = 8'b0_1110_010;
  localparam logic [7:0] O_FAULT = 8'b0_0001_011;

  typedef struct {
    int         rel;
    logic       lock;
    logic       rst;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [7:0] exp;
    string      name;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       locked;
  logic       restart;
  logic       pll_resetb;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [2:0] state;
`ifdef PLL_LOCK_SEQUENCER_STATUS_EN
  logic [7:0] lock_loss_cnt;
`endif
  logic [7:0] outs;

  int   cyc;
  int   base;
  int   n_vec;
  int   n_err;
  vec_t vecs[$];
  exp_t exp_q[$];

  pll_lock_sequencer dut (
    .clock_in   (clk),
    .reset_n    (reset_n),
    .locked     (locked),
    .restart    (restart),
    .pll_resetb (pll_resetb),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fault      (fault),
    .state      (state)
`ifdef PLL_LOCK_SEQUENCER_STATUS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  assign outs = {1'b0, pll_resetb, sys_rst_n, ready, fault, state};

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Lock timeout phase starting with a PLL reset at cycle 'start', locked never qualifying.
  function automatic logic [7:0] phase_exp(input int c, input int start);
    int off;
    int att;
    off = c - start;
    att = off / PER;
    if (att >= MAXR + 1) return O_FAULT;
    return ((off % PER) < RSTC) ? O_RST : O_WAIT;
  endfunction

  function automatic logic lock_at(input int c);
    if (c < 10)  return 1'b0;
    if (c < 30)  return 1'b1;
    if (c == 30) return 1'b0;
    if (c < 70)  return 1'b1;
    if (c < 75)  return 1'b0;
    if (c < 277) return (((c - 75) / 5) % 2) == 0;
    if (c < 330) return 1'b1;
    if (c < 391) return 1'b0;
    if (c < 410) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic restart_at(input int c);
    return (c == 50) || (c == 310) || (c == 490);
  endfunction

  // Expected timeline (cycle c = number of clock edges since reset release).
  function automatic logic [7:0] exp_at(input int c);
    if (c < 4)   return O_RST;    // initial PLL reset
    if (c < 20)  return O_WAIT;   // lock rises at 10, 2 sync + 8 stable
    if (c < 33)  return O_RUN;    // 1-cycle lock drop at 30 seen 3 edges later
    if (c < 37)  return O_RST;
    if (c < 45)  return O_WAIT;   // relock
    if (c < 51)  return O_RUN;    // restart at 50
    if (c < 55)  return O_RST;
    if (c < 63)  return O_WAIT;
    if (c < 73)  return O_RUN;    // lock lost at 70, then toggling every 5 cycles
    if (c < 311) return phase_exp(c, 73);  // three timeouts then FAULT; restart at 310
    if (c < 315) return O_RST;
    if (c < 323) return O_WAIT;
    if (c < 333) return O_RUN;    // lock lost at 330
    if (c < 337) return O_RST;
    if (c < 401) return O_WAIT;   // stable threshold lands on the timeout cycle
    if (c < 413) return O_RUN;    // lock lost at 410
    if (c < 491) return phase_exp(c, 413);  // one timeout, restart at 490
    return phase_exp(c, 491);     // retries start again from zero
  endfunction

  // scoreboard: pop and compare whenever the DUT reaches an expected cycle
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      if (e.cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: check for cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
      end else begin
        check(e.name, outs, e.exp);
      end
    end
  end

  initial begin
    vec_t v;
    n_vec = 0;
    n_err = 0;
    for (int c = 1; c <= LAST; c++) begin
      v.rel  = c;
      v.lock = lock_at(c);
      v.rst  = restart_at(c);
      v.exp  = exp_at(c);
      vecs.push_back(v);
    end

    reset_n = 1'b0;
    locked  = 1'b0;
    restart = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hold", outs, O_RST);
    base = cyc;
    reset_n = 1'b1;
    check("reset_release_c0", outs, O_RST);

    foreach (vecs[i]) begin
      exp_q.push_back('{base + vecs[i].rel, vecs[i].exp, "timeline"});
      while (cyc != base + vecs[i].rel) @(negedge clk);
      locked  = vecs[i].lock;
      restart = vecs[i].rst;
    end
`ifdef PLL_LOCK_SEQUENCER_STATUS_EN
    check("lock_loss_cnt", lock_loss_cnt, 8'd4);
`endif
    check("fault_hold", outs, O_FAULT);

    // Get back into RUN, then drop reset_n between clock edges.
    locked  = 1'b1;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    for (int i = 0; i < 40 && !ready; i++) @(negedge clk);
    check("run_before_reset", outs, O_RUN);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset", outs, O_RST);
`ifdef PLL_LOCK_SEQUENCER_STATUS_EN
    check("lock_loss_cnt_reset", lock_loss_cnt, 8'd0);
`endif

    // Release with locked already high: full PLL reset, then qualification.
    @(negedge clk);
    base = cyc;
    for (int r = 1; r <= STAB + RSTC + 1; r++)
      exp_q.push_back('{base + r, (r < RSTC) ? O_RST : ((r < RSTC + STAB) ? O_WAIT : O_RUN),
                        "rerelease"});
    reset_n = 1'b1;
    repeat (STAB + RSTC + 3) @(negedge clk);

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
